// File: rtl/matching_unit.sv
// Operand matching unit: pairs LEFT/RIGHT tokens by {dest_addr, color} in a small
// associative waiting store and forwards fired operand packets; ONE/EXEC bypass the store.
module matching_unit #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RECEIVE_PR_VALID,
  input  logic [98:0]          RECEIVE_PR_DATA,
  output logic                 RECEIVE_PR_READY,
  output logic                 SEND_OP_VALID,
  output logic [95:0]          SEND_OP_DATA,
  input  logic                 SEND_OP_READY,
  output logic [CNT_WIDTH-1:0] STORE_COUNT,
  output logic                 OVERFLOW
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OPT_ONE   = 3'd1;
  localparam logic [2:0] OPT_LEFT  = 3'd2;
  localparam logic [2:0] OPT_RIGHT = 3'd3;
  localparam logic [2:0] OPT_EXEC  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_SEND} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ready;
  logic                 r_valid;
  logic [95:0]          r_out_data;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_overflow;

  // Latched request
  logic [2:0]           r_req_opt;
  logic [15:0]          r_req_addr;
  logic [15:0]          r_req_color;
  logic [31:0]          r_req_d1;
  logic [31:0]          r_req_d2;

  // Waiting store; side bit 0 = LEFT, 1 = RIGHT
  logic [DEPTH-1:0]     r_ent_vld;
  logic [15:0]          r_ent_addr  [DEPTH];
  logic [15:0]          r_ent_color [DEPTH];
  logic                 r_ent_side  [DEPTH];
  logic [31:0]          r_ent_data  [DEPTH];

  logic                 w_accept;
  logic                 w_req_side;
  logic                 w_full;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_free;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_fire;
  logic                 w_take_hit;
  logic                 w_store;
  logic                 w_drop;
  logic [95:0]          w_fire_data;

  assign w_accept   = RECEIVE_PR_VALID && r_ready && (r_state == S_IDLE);
  assign w_req_side = r_req_opt[0];
  assign w_full     = (r_count == CNT_WIDTH'(DEPTH));

  // Lowest-index hit (opposite side, same tag) and lowest-index free slot
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && r_ent_vld[i] && (r_ent_addr[i] == r_req_addr) &&
          (r_ent_color[i] == r_req_color) && (r_ent_side[i] != w_req_side)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!w_free && !r_ent_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_take_hit  = 1'b0;
    w_store     = 1'b0;
    w_drop      = 1'b0;
    w_fire_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_MATCH;
      end
      S_MATCH: begin
        w_state_nxt = S_IDLE;
        case (r_req_opt)
          OPT_ONE: begin
            w_fire      = 1'b1;
            w_fire_data = {r_req_addr, r_req_color, r_req_d1, 32'b0};
            w_state_nxt = S_SEND;
          end
          OPT_EXEC: begin
            w_fire      = 1'b1;
            w_fire_data = {r_req_addr, r_req_color, r_req_d1, r_req_d2};
            w_state_nxt = S_SEND;
          end
          OPT_LEFT, OPT_RIGHT: begin
            if (w_hit) begin
              w_fire      = 1'b1;
              w_take_hit  = 1'b1;
              // LEFT operand always lands in data1 regardless of arrival order
              w_fire_data = w_req_side ?
                {r_req_addr, r_req_color, r_ent_data[w_hit_idx], r_req_d1} :
                {r_req_addr, r_req_color, r_req_d1, r_ent_data[w_hit_idx]};
              w_state_nxt = S_SEND;
            end else if (w_full || !w_free) begin
              w_drop = 1'b1;
            end else begin
              w_store = 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_SEND: begin
        if (SEND_OP_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and store occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_out_data <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ent_vld  <= '0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_valid <= (w_state_nxt == S_SEND);
      if (w_fire) r_out_data <= w_fire_data;
      if (w_drop) r_overflow <= 1'b1;
      if (w_take_hit) begin
        r_ent_vld[w_hit_idx] <= 1'b0;
        r_count              <= r_count - 1'b1;
      end else if (w_store) begin
        r_ent_vld[w_free_idx] <= 1'b1;
        r_count               <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_req_opt   <= RECEIVE_PR_DATA[98:96];
      r_req_addr  <= RECEIVE_PR_DATA[95:80];
      r_req_color <= RECEIVE_PR_DATA[79:64];
      r_req_d1    <= RECEIVE_PR_DATA[63:32];
      r_req_d2    <= RECEIVE_PR_DATA[31:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_ent_addr[w_free_idx]  <= r_req_addr;
      r_ent_color[w_free_idx] <= r_req_color;
      r_ent_side[w_free_idx]  <= w_req_side;
      r_ent_data[w_free_idx]  <= r_req_d1;
    end
  end

  assign RECEIVE_PR_READY = r_ready;
  assign SEND_OP_VALID    = r_valid;
  assign SEND_OP_DATA     = r_out_data;
  assign STORE_COUNT      = r_count;
  assign OVERFLOW         = r_overflow;

endmodule

// File: tb/tb_matching_unit.sv
// Directed bench for matching_unit: expected fired packets are queued when stimulus
// is driven and compared when the DUT completes an output handshake.
module tb_matching_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        RECEIVE_PR_VALID = 1'b0;
  logic [98:0] RECEIVE_PR_DATA = '0;
  logic        RECEIVE_PR_READY;
  logic        SEND_OP_VALID;
  logic [95:0] SEND_OP_DATA;
  logic        SEND_OP_READY = 1'b1;
  logic [3:0]  STORE_COUNT;
  logic        OVERFLOW;

  int n_checks = 0;
  int n_pass   = 0;
  logic [95:0] exp_q[$];

  always #5 CLK = ~CLK;

  matching_unit #(.DEPTH(8), .CNT_WIDTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RECEIVE_PR_VALID(RECEIVE_PR_VALID), .RECEIVE_PR_DATA(RECEIVE_PR_DATA),
    .RECEIVE_PR_READY(RECEIVE_PR_READY),
    .SEND_OP_VALID(SEND_OP_VALID), .SEND_OP_DATA(SEND_OP_DATA),
    .SEND_OP_READY(SEND_OP_READY),
    .STORE_COUNT(STORE_COUNT), .OVERFLOW(OVERFLOW)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Handshake completes at the posedge following a negedge with VALID && READY high
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && SEND_OP_VALID === 1'b1 && SEND_OP_READY === 1'b1) begin
      check("out_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("out_data", SEND_OP_DATA, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] opt, input logic [15:0] a, input logic [15:0] c,
                      input logic [31:0] d1, input logic [31:0] d2);
    bit ok;
    tick();
    RECEIVE_PR_VALID = 1'b1;
    RECEIVE_PR_DATA  = {opt, a, c, d1, d2};
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (RECEIVE_PR_READY === 1'b1) ok = 1'b1;
    end
    check("accept_timeout", ok, 1'b1);
    tick();
    RECEIVE_PR_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge CLK);
      if (RECEIVE_PR_READY === 1'b1) ok = 1'b1;
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  task automatic do_reset();
    tick();
    RST_N = 1'b0;
    exp_q.delete();
    tick();
    tick();
    RST_N = 1'b1;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 RST_N = 1'b0;
    @(negedge CLK);
    check("rst_valid", SEND_OP_VALID, 1'b0);
    check("rst_ready", RECEIVE_PR_READY, 1'b0);
    check("rst_data", SEND_OP_DATA, 96'h0);
    check("rst_count", STORE_COUNT, 4'd0);
    check("rst_ovf", OVERFLOW, 1'b0);
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("ready_after_rst", RECEIVE_PR_READY, 1'b1);

    // ONE: data2 forced to zero, latency t+2, ready back at t+3
    exp_q.push_back({16'h0010, 16'h0003, 32'hDEADBEEF, 32'h0});
    send(3'd1, 16'h0010, 16'h0003, 32'hDEADBEEF, 32'h12345678);
    @(negedge CLK);
    check("one_t1_valid", SEND_OP_VALID, 1'b0);
    check("one_t1_ready", RECEIVE_PR_READY, 1'b0);
    @(negedge CLK);
    check("one_t2_valid", SEND_OP_VALID, 1'b1);
    check("one_t2_data", SEND_OP_DATA, {16'h0010, 16'h0003, 32'hDEADBEEF, 32'h0});
    @(negedge CLK);
    check("one_t3_valid", SEND_OP_VALID, 1'b0);
    check("one_t3_ready", RECEIVE_PR_READY, 1'b1);
    check("one_count", STORE_COUNT, 4'd0);

    // LEFT then RIGHT, and reversed order
    send(3'd2, 16'h0020, 16'h0001, 32'd5, 32'd0);
    wait_idle();
    check("lr_count1", STORE_COUNT, 4'd1);
    exp_q.push_back({16'h0020, 16'h0001, 32'd5, 32'd7});
    send(3'd3, 16'h0020, 16'h0001, 32'd7, 32'd0);
    wait_idle();
    check("lr_count0", STORE_COUNT, 4'd0);
    send(3'd3, 16'h0020, 16'h0001, 32'd7, 32'd0);
    wait_idle();
    check("rl_count1", STORE_COUNT, 4'd1);
    exp_q.push_back({16'h0020, 16'h0001, 32'd5, 32'd7});
    send(3'd2, 16'h0020, 16'h0001, 32'd5, 32'd0);
    wait_idle();
    check("rl_count0", STORE_COUNT, 4'd0);

    // Tags differing only in color never pair
    send(3'd2, 16'h0020, 16'h0001, 32'd9, 32'd0);
    wait_idle();
    send(3'd3, 16'h0020, 16'h0002, 32'd10, 32'd0);
    wait_idle();
    check("color_count", STORE_COUNT, 4'd2);

    // Same-side duplicates stay separate; lowest index (earliest) matches first
    do_reset();
    send(3'd2, 16'h0030, 16'h0000, 32'd1, 32'd0);
    wait_idle();
    send(3'd2, 16'h0030, 16'h0000, 32'd2, 32'd0);
    wait_idle();
    check("dup_count2", STORE_COUNT, 4'd2);
    exp_q.push_back({16'h0030, 16'h0000, 32'd1, 32'd3});
    send(3'd3, 16'h0030, 16'h0000, 32'd3, 32'd0);
    wait_idle();
    exp_q.push_back({16'h0030, 16'h0000, 32'd2, 32'd4});
    send(3'd3, 16'h0030, 16'h0000, 32'd4, 32'd0);
    wait_idle();
    check("dup_count0", STORE_COUNT, 4'd0);

    // EXEC passes through unchanged; NOP and reserved options are discarded
    exp_q.push_back({16'h0040, 16'h0005, 32'h11, 32'h22});
    send(3'd4, 16'h0040, 16'h0005, 32'h11, 32'h22);
    wait_idle();
    send(3'd0, 16'h0041, 16'h0005, 32'h33, 32'h44);
    wait_idle();
    send(3'd6, 16'h0042, 16'h0005, 32'h55, 32'h66);
    wait_idle();
    check("nop_count", STORE_COUNT, 4'd0);

    // Fill the store, overflow, then free entry 3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(3'd2, 16'h0100 + 16'(i), 16'(i), 32'hA0 + 32'(i), 32'd0);
      wait_idle();
    end
    check("fill_count", STORE_COUNT, 4'd8);
    check("fill_ovf", OVERFLOW, 1'b0);
    send(3'd2, 16'h0099, 16'h0000, 32'hBB, 32'd0);
    wait_idle();
    check("ovf_count", STORE_COUNT, 4'd8);
    check("ovf_flag", OVERFLOW, 1'b1);
    exp_q.push_back({16'h0103, 16'h0003, 32'hA3, 32'h77});
    send(3'd3, 16'h0103, 16'h0003, 32'h77, 32'd0);
    wait_idle();
    check("ovf_fire_count", STORE_COUNT, 4'd7);
    check("ovf_sticky", OVERFLOW, 1'b1);

    // Backpressure: output held stable, input not ready, one transfer on release
    do_reset();
    send(3'd2, 16'h0050, 16'h0006, 32'd1, 32'd0);
    wait_idle();
    tick();
    SEND_OP_READY = 1'b0;
    exp_q.push_back({16'h0050, 16'h0006, 32'd1, 32'd2});
    send(3'd3, 16'h0050, 16'h0006, 32'd2, 32'd0);
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_valid", SEND_OP_VALID, 1'b1);
      check("bp_data", SEND_OP_DATA, {16'h0050, 16'h0006, 32'd1, 32'd2});
      check("bp_ready", RECEIVE_PR_READY, 1'b0);
    end
    tick();
    SEND_OP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_release_valid", SEND_OP_VALID, 1'b0);
    check("bp_queue", exp_q.size(), 0);

    // Async reset while in S_SEND with three entries stored
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(3'd2, 16'h0060 + 16'(i), 16'h0001, 32'(i), 32'd0);
      wait_idle();
    end
    check("ar_count3", STORE_COUNT, 4'd3);
    tick();
    SEND_OP_READY = 1'b0;
    send(3'd1, 16'h0070, 16'h0007, 32'h99, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("ar_in_send", SEND_OP_VALID, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("ar_valid", SEND_OP_VALID, 1'b0);
    check("ar_data", SEND_OP_DATA, 96'h0);
    check("ar_ready", RECEIVE_PR_READY, 1'b0);
    check("ar_count", STORE_COUNT, 4'd0);
    check("ar_ovf", OVERFLOW, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    SEND_OP_READY = 1'b1;
    wait_idle();
    send(3'd0, 16'h0001, 16'h0001, 32'h1, 32'h1);
    wait_idle();
    check("ar_nop_count", STORE_COUNT, 4'd0);
    check("ar_nop_valid", SEND_OP_VALID, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
